// File: rtl/pulse_stretch_pkg.sv
// Shared types and constants for the pulse stretcher.
package pulse_stretch_pkg;

    localparam int CNT_W = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } ps_state_t;

endpackage

// File: rtl/pulse_stretch_dwell_timer.sv
// Dwell timer: free-running cycle counter with synchronous clear and a
// terminal-count flag compared against a runtime limit.
module dwell_timer
    import pulse_stretch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    // Count cycles spent in the current state; clear restarts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Terminal count: this is the last cycle of the dwell.
    always_comb begin
        tc = (cnt == limit);
    end

endmodule

// File: rtl/pulse_stretch.sv
// Pulse stretcher: each trig_in rising edge becomes a HOLD_CNT-cycle high
// pulse followed by a GAP_CNT-cycle low gap. Edges arriving while a pulse
// is in flight are queued in a saturating counter and replayed in order.
//
// Handshake: trig_in is a level, no ready; every 0->1 transition seen at a
// posedge is one request. Requests are never back-pressured, they are either
// queued, consumed at once, or dropped (flagged by the sticky overflow bit).
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter logic [CNT_W-1:0] HOLD_CNT = 20'd500000,
    parameter logic [CNT_W-1:0] GAP_CNT  = 20'd500000,
    parameter int               PEND_W   = 4
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig_in,
    input  logic              clr_ovf,
    output logic              sig_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow,
    output logic [1:0]        state_dbg
);

    localparam logic [CNT_W-1:0]  HOLD_LIM = HOLD_CNT - CNT_W'(1);
    localparam logic [CNT_W-1:0]  GAP_LIM  = GAP_CNT - CNT_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    if (HOLD_CNT == '0 || GAP_CNT == '0) begin : g_bad_param
        $error("pulse_stretch: HOLD_CNT and GAP_CNT must be non-zero");
    end

    ps_state_t         state, state_nxt;
    logic              trig_q;
    logic              ev;
    logic              drop;
    logic              tc;
    logic              tmr_clr;
    logic [CNT_W-1:0]  limit;
    logic [PEND_W-1:0] pend_nxt;
    logic              ovf_nxt;

    // Remember the previous trig_in level to find rising edges; reset high
    // so a level held through reset release is not an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q <= 1'b1;
        end else begin
            trig_q <= trig_in;
        end
    end

    // Rising-edge event, limit select and timer clear on state entry.
    always_comb begin
        ev      = trig_in & ~trig_q;
        limit   = (state == HOLD) ? HOLD_LIM : GAP_LIM;
        tmr_clr = (state_nxt != state) || (state == IDLE);
    end

    dwell_timer u_dwell_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .limit (limit),
        .tc    (tc)
    );

    // Next state, pending queue and overflow decisions.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pending;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (ev) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (tc) begin
                    state_nxt = GAP;
                end
                if (ev) begin
                    if (pending != PEND_MAX) pend_nxt = pending + PEND_ONE;
                    else                     drop     = 1'b1;
                end
            end
            GAP: begin
                if (tc) begin
                    // A new edge on the final gap cycle stands in for one
                    // queued event, so it either cancels the decrement or
                    // is consumed directly when nothing is queued.
                    if (pending != '0 || ev) begin
                        state_nxt = HOLD;
                        if (pending != '0 && !ev) pend_nxt = pending - PEND_ONE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (ev) begin
                    if (pending != PEND_MAX) pend_nxt = pending + PEND_ONE;
                    else                     drop     = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // A drop in the same cycle as a clear request keeps the flag set.
        if (drop)         ovf_nxt = 1'b1;
        else if (clr_ovf) ovf_nxt = 1'b0;
        else              ovf_nxt = overflow;
    end

    // State, registered output and queue registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sig_out  <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            sig_out  <= (state_nxt == HOLD);
            pending  <= pend_nxt;
            overflow <= ovf_nxt;
        end
    end

    // Status outputs decoded from state.
    always_comb begin
        busy      = (state != IDLE);
        state_dbg = state;
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch with HOLD_CNT=4, GAP_CNT=3, PEND_W=2.
// The reference model works on a pulse timeline: the posedge at which the
// current pulse started, plus a queued-event count.
module tb_pulse_stretch;

    localparam int H    = 4;
    localparam int G    = 3;
    localparam int PW   = 2;
    localparam int PMAX = (1 << PW) - 1;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          trig_in;
    logic          clr_ovf;
    logic          sig_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;
    logic [1:0]    state_dbg;

    always #5 clk = ~clk;

    pulse_stretch #(
        .HOLD_CNT (20'd4),
        .GAP_CNT  (20'd3),
        .PEND_W   (PW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig_in   (trig_in),
        .clr_ovf   (clr_ovf),
        .sig_out   (sig_out),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int cyc;
    int s;
    bit act;
    int pend;
    bit ovf;
    bit tprev;
    bit m_ev;
    bit m_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; s = 0; act = 0; pend = 0; ovf = 0; tprev = 1;
        end else begin
            cyc++;
            m_ev   = trig_in && !tprev;
            tprev  = trig_in;
            m_drop = 0;
            if (!act) begin
                if (m_ev) begin act = 1; s = cyc; end
            end else if (cyc - s == H + G) begin
                if (pend > 0 || m_ev) begin
                    s = cyc;
                    if (pend > 0 && !m_ev) pend--;
                end else begin
                    act = 0;
                end
            end else if (m_ev) begin
                if (pend < PMAX) pend++;
                else             m_drop = 1;
            end
            if (m_drop)       ovf = 1;
            else if (clr_ovf) ovf = 0;
        end
    end

    // ---------------- scoreboard / compare ----------------
    int  pulses;
    int  busy_cyc;
    int  peak;
    logic sig_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("sig_out",  int'(sig_out),  int'(act && (cyc - s) < H));
            check("busy",     int'(busy),     int'(act));
            check("pending",  int'(pending),  pend);
            check("overflow", int'(overflow), int'(ovf));
            if (sig_out && !sig_prev) pulses++;
            if (busy) busy_cyc++;
            if (int'(pending) > peak) peak = int'(pending);
            sig_prev = sig_out;
        end else begin
            sig_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_stats();
        pulses = 0; busy_cyc = 0; peak = 0;
    endtask

    // One event: trig high across one posedge, then low across the next.
    task automatic pulse();
        trig_in = 1'b1;
        step();
        trig_in = 1'b0;
        step();
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) step();
        check("wait_idle", int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; trig_in = 1'b0; clr_ovf = 1'b0;
        clear_stats();
        #23;
        rst_n = 1'b1;
        check("rst_sig",  int'(sig_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pend", int'(pending), 0);
        check("rst_ovf",  int'(overflow), 0);
        step();

        // Single pulse: 4 high, 7 busy cycles.
        clear_stats();
        trig_in = 1'b1; step(); trig_in = 1'b0;
        check("single_high", int'(sig_out), 1);
        step();
        wait_idle(40);
        check("single_pulses", pulses, 1);
        check("single_busy", busy_cyc, 7);
        check("single_peak", peak, 0);
        step();

        // Burst of three edges: three back-to-back pulses.
        clear_stats();
        pulse(); pulse(); pulse();
        wait_idle(60);
        check("burst_pulses", pulses, 3);
        check("burst_busy", busy_cyc, 21);
        check("burst_peak", peak, 2);
        check("burst_ovf", int'(overflow), 0);
        step();

        // Saturation: six edges, the last one dropped.
        clear_stats();
        for (int i = 0; i < 6; i++) pulse();
        check("sat_ovf", int'(overflow), 1);
        check("sat_pend", int'(pending), 3);
        wait_idle(100);
        check("sat_pulses", pulses, 5);
        check("sat_ovf_hold", int'(overflow), 1);
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        check("sat_ovf_clr", int'(overflow), 0);
        step();

        // Reset release with trig_in held high: no event.
        rst_n = 1'b0; trig_in = 1'b1;
        step(); step();
        rst_n = 1'b1;
        clear_stats();
        repeat (4) step();
        check("rel_pulses", pulses, 0);
        check("rel_busy", int'(busy), 0);
        trig_in = 1'b0; step();
        trig_in = 1'b1; step();
        trig_in = 1'b0;
        wait_idle(40);
        check("rel_pulses2", pulses, 1);
        step();

        // Async reset in the second pulse's HOLD with two queued.
        clear_stats();
        for (int i = 0; i < 4; i++) pulse();
        check("ar_pend", int'(pending), 2);
        check("ar_sig", int'(sig_out), 1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_sig0", int'(sig_out), 0);
        check("ar_busy0", int'(busy), 0);
        check("ar_pend0", int'(pending), 0);
        step(); step();
        rst_n = 1'b1;
        clear_stats();
        repeat (20) step();
        check("ar_pulses", pulses, 0);
        check("ar_busy", int'(busy), 0);

        // Edge on the final gap cycle with one queued.
        clear_stats();
        pulse(); pulse();
        repeat (3) step();
        trig_in = 1'b1; step(); trig_in = 1'b0;
        check("fg1_pend", int'(pending), 1);
        check("fg1_sig", int'(sig_out), 1);
        wait_idle(60);
        check("fg1_pulses", pulses, 3);
        step();

        // Edge on the final gap cycle with nothing queued.
        clear_stats();
        pulse();
        repeat (5) step();
        trig_in = 1'b1; step(); trig_in = 1'b0;
        check("fg0_pend", int'(pending), 0);
        check("fg0_sig", int'(sig_out), 1);
        wait_idle(40);
        check("fg0_pulses", pulses, 2);
        check("fg0_busy", busy_cyc, 14);
        step();

        // Randomized traffic against the model.
        repeat (3000) begin
            trig_in = ($urandom_range(0, 2) == 0);
            clr_ovf = ($urandom_range(0, 15) == 0);
            step();
        end
        trig_in = 1'b0; clr_ovf = 1'b0;
        wait_idle(100);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
